// File: rtl/uart_time_reporter.sv
`default_nettype none
// ============================================================================
// Module   : uart_time_reporter
// Brief    : Snapshots hour/min/sec/centisecond and sends "HH:MM:SS.CC\r\n"
//            as 13 bytes over an 8N1 UART TX line.
// Revision : 1.0 - initial release
// ============================================================================
module uart_time_reporter #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_send,
    input  logic [6:0] msec,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hour,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    localparam int c_div   = CLK_FREQ / BAUD;
    localparam int c_cnt_w = (c_div > 1) ? $clog2(c_div) : 1;
    localparam logic [c_cnt_w-1:0] c_baud_last = c_cnt_w'(c_div - 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_start = 2'd1;
    localparam logic [1:0] c_data  = 2'd2;
    localparam logic [1:0] c_stop  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_cnt_w-1:0] r_baud;
    logic [2:0]         r_bit;
    logic [3:0]         r_byte;
    logic               r_done;
    logic [6:0]         r_msec;
    logic [5:0]         r_sec;
    logic [5:0]         r_min;
    logic [4:0]         r_hour;
    logic [7:0]         w_byte;
    logic               w_bit_end;
    logic               w_last_byte;
    logic               w_accept;

    function automatic logic [7:0] ascii_tens(input logic [6:0] v);
        logic [6:0] d;
        d = v / 7'd10;
        return {1'b0, d} + 8'h30;
    endfunction

    function automatic logic [7:0] ascii_ones(input logic [6:0] v);
        logic [6:0] d;
        d = v % 7'd10;
        return {1'b0, d} + 8'h30;
    endfunction

    assign w_bit_end   = (r_baud == c_baud_last);
    assign w_last_byte = (r_byte == 4'd12);
    assign w_accept    = (r_state == c_idle) && i_send;

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_idle;
        else     r_state <= w_next_state;
    end

    // The byte-advance step is folded into the STOP exit so stop and next start are contiguous
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (i_send) w_next_state = c_start;
            c_start: if (w_bit_end) w_next_state = c_data;
            c_data:  if (w_bit_end && (r_bit == 3'd7)) w_next_state = c_stop;
            c_stop:  if (w_bit_end) w_next_state = w_last_byte ? c_idle : c_start;
            default: w_next_state = c_idle;
        endcase
    end

    always_comb begin
        o_tx = 1'b1;
        case (r_state)
            c_start: o_tx = 1'b0;
            c_data:  o_tx = w_byte[r_bit];
            default: o_tx = 1'b1;
        endcase
        o_busy = (r_state != c_idle);
        o_done = r_done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud <= '0;
            r_bit  <= 3'd0;
            r_byte <= 4'd0;
            r_done <= 1'b0;
            r_msec <= 7'd0;
            r_sec  <= 6'd0;
            r_min  <= 6'd0;
            r_hour <= 5'd0;
        end else begin
            r_done <= (r_state == c_stop) && w_bit_end && w_last_byte;

            if ((r_state == c_idle) || w_bit_end) r_baud <= '0;
            else                                  r_baud <= r_baud + 1'b1;

            if (r_state != c_data) r_bit <= 3'd0;
            else if (w_bit_end)    r_bit <= r_bit + 3'd1;

            if ((r_state == c_stop) && w_bit_end)
                r_byte <= w_last_byte ? 4'd0 : r_byte + 4'd1;

            if (w_accept) begin
                r_msec <= (msec > 7'd99) ? 7'd99 : msec;
                r_sec  <= sec;
                r_min  <= min;
                r_hour <= hour;
            end
        end
    end

    always_comb begin
        w_byte = 8'h0A;
        case (r_byte)
            4'd0:  w_byte = ascii_tens({2'b00, r_hour});
            4'd1:  w_byte = ascii_ones({2'b00, r_hour});
            4'd2:  w_byte = 8'h3A;
            4'd3:  w_byte = ascii_tens({1'b0, r_min});
            4'd4:  w_byte = ascii_ones({1'b0, r_min});
            4'd5:  w_byte = 8'h3A;
            4'd6:  w_byte = ascii_tens({1'b0, r_sec});
            4'd7:  w_byte = ascii_ones({1'b0, r_sec});
            4'd8:  w_byte = 8'h2E;
            4'd9:  w_byte = ascii_tens(r_msec);
            4'd10: w_byte = ascii_ones(r_msec);
            4'd11: w_byte = 8'h0D;
            default: w_byte = 8'h0A;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_time_reporter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_time_reporter
// Brief    : Directed self-checking bench for uart_time_reporter at DIV=10.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_time_reporter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_send = 1'b0;
    logic [6:0] msec = 7'd0;
    logic [5:0] sec = 6'd0;
    logic [5:0] min = 6'd0;
    logic [4:0] hour = 5'd0;
    wire        o_tx;
    wire        o_busy;
    wire        o_done;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int t0 = 0;
    logic [7:0] rx_buf [13];
    bit rx_ok;

    uart_time_reporter #(.CLK_FREQ(1000), .BAUD(100)) dut (
        .clk(clk), .rst(rst), .i_send(i_send),
        .msec(msec), .sec(sec), .min(min), .hour(hour),
        .o_tx(o_tx), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (o_done === 1'b1) done_cnt++;

    // Called at a negedge; returns at the negedge after the start bit appears on the line
    task automatic start_frame();
        i_send = 1'b1;
        @(negedge clk);
        i_send = 1'b0;
        t0 = cyc;
    endtask

    task automatic rx_byte(output logic [7:0] b, output bit ok);
        int n;
        ok = 1; b = 8'h00; n = 0;
        while (o_tx !== 1'b0 && n < 300) begin @(negedge clk); n++; end
        if (o_tx !== 1'b0) begin ok = 0; return; end
        repeat (5) @(negedge clk);
        if (o_tx !== 1'b0) ok = 0;
        for (int i = 0; i < 8; i++) begin
            repeat (10) @(negedge clk);
            b[i] = o_tx;
        end
        repeat (10) @(negedge clk);
        if (o_tx !== 1'b1) ok = 0;
    endtask

    task automatic rx_line();
        bit ok;
        rx_ok = 1;
        for (int k = 0; k < 13; k++) begin
            rx_byte(rx_buf[k], ok);
            if (!ok) rx_ok = 0;
        end
    endtask

    task automatic wait_done(output int at);
        int n;
        n = 0;
        while (o_done !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        at = (o_done === 1'b1) ? cyc : -1;
    endtask

    task automatic test_reset();
        bit seen_low;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (o_tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", o_tx); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", o_busy); end
        total++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", o_done); end
        rst = 1'b0;
        seen_low = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (o_tx !== 1'b1 || o_busy !== 1'b0) seen_low = 1;
        end
        total++; if (seen_low) begin bad++; $display("FAIL reset_idle activity=%b want=0", seen_low); end
    endtask

    task automatic test_basic();
        logic [7:0] exp [13];
        int at, d0;
        exp = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36, 8'h2E, 8'h37, 8'h38, 8'h0D, 8'h0A};
        hour = 5'd12; min = 6'd34; sec = 6'd56; msec = 7'd78;
        d0 = done_cnt;
        start_frame();
        total++; if (o_tx !== 1'b0) begin bad++; $display("FAIL basic_latency_tx got=%b want=0", o_tx); end
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL basic_latency_busy got=%b want=1", o_busy); end
        rx_line();
        total++; if (!rx_ok) begin bad++; $display("FAIL basic_framing got=%b want=1", rx_ok); end
        for (int k = 0; k < 13; k++) begin
            total++;
            if (rx_buf[k] !== exp[k]) begin bad++; $display("FAIL basic_byte%0d got=%h want=%h", k, rx_buf[k], exp[k]); end
        end
        wait_done(at);
        total++; if (at !== t0 + 1300) begin bad++; $display("FAIL basic_done_time got=%0d want=%0d", at - t0, 1300); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL basic_busy_in_done got=%b want=0", o_busy); end
        @(negedge clk);
        total++; if (o_done !== 1'b0) begin bad++; $display("FAIL basic_done_width got=%b want=0", o_done); end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL basic_done_count got=%0d want=1", done_cnt - d0); end
    endtask

    task automatic test_snapshot();
        logic [7:0] exp [13];
        exp = '{8'h30, 8'h31, 8'h3A, 8'h30, 8'h32, 8'h3A, 8'h30, 8'h33, 8'h2E, 8'h30, 8'h34, 8'h0D, 8'h0A};
        hour = 5'd1; min = 6'd2; sec = 6'd3; msec = 7'd4;
        start_frame();
        fork
            rx_line();
            begin
                repeat (50) @(negedge clk);
                hour = 5'd23; min = 6'd59; sec = 6'd48; msec = 7'd97;
            end
        join
        total++; if (!rx_ok) begin bad++; $display("FAIL snap_framing got=%b want=1", rx_ok); end
        for (int k = 0; k < 13; k++) begin
            total++;
            if (rx_buf[k] !== exp[k]) begin bad++; $display("FAIL snap_byte%0d got=%h want=%h", k, rx_buf[k], exp[k]); end
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        logic [7:0] exp [13];
        int at, d0;
        bit active;
        exp = '{8'h32, 8'h33, 8'h3A, 8'h34, 8'h35, 8'h3A, 8'h30, 8'h36, 8'h2E, 8'h39, 8'h39, 8'h0D, 8'h0A};
        hour = 5'd23; min = 6'd45; sec = 6'd6; msec = 7'd99;
        d0 = done_cnt;
        start_frame();
        fork
            rx_line();
            begin
                repeat (399) @(negedge clk);
                i_send = 1'b1;
                @(negedge clk);
                i_send = 1'b0;
            end
        join
        for (int k = 0; k < 13; k++) begin
            total++;
            if (rx_buf[k] !== exp[k]) begin bad++; $display("FAIL busy_byte%0d got=%h want=%h", k, rx_buf[k], exp[k]); end
        end
        wait_done(at);
        total++; if (at !== t0 + 1300) begin bad++; $display("FAIL busy_done_time got=%0d want=%0d", at - t0, 1300); end
        active = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (o_tx !== 1'b1 || o_busy !== 1'b0) active = 1;
        end
        total++; if (active) begin bad++; $display("FAIL busy_idle_after activity=%b want=0", active); end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL busy_done_count got=%0d want=1", done_cnt - d0); end
    endtask

    task automatic test_saturation();
        logic [7:0] exp [13];
        exp = '{8'h30, 8'h30, 8'h3A, 8'h35, 8'h39, 8'h3A, 8'h30, 8'h30, 8'h2E, 8'h39, 8'h39, 8'h0D, 8'h0A};
        hour = 5'd0; min = 6'd59; sec = 6'd0; msec = 7'd120;
        start_frame();
        rx_line();
        total++; if (!rx_ok) begin bad++; $display("FAIL sat_framing got=%b want=1", rx_ok); end
        for (int k = 0; k < 13; k++) begin
            total++;
            if (rx_buf[k] !== exp[k]) begin bad++; $display("FAIL sat_byte%0d got=%h want=%h", k, rx_buf[k], exp[k]); end
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int at;
        hour = 5'd7; min = 6'd8; sec = 6'd9; msec = 7'd10;
        start_frame();
        rx_line();
        wait_done(at);
        total++; if (at !== t0 + 1300) begin bad++; $display("FAIL b2b_done_time got=%0d want=%0d", at - t0, 1300); end
        hour = 5'd31; min = 6'd63; sec = 6'd63; msec = 7'd99;
        start_frame();
        total++; if (o_tx !== 1'b0) begin bad++; $display("FAIL b2b_restart_tx got=%b want=0", o_tx); end
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL b2b_restart_busy got=%b want=1", o_busy); end
        rx_line();
        total++; if (rx_buf[0] !== 8'h33) begin bad++; $display("FAIL b2b_byte0 got=%h want=33", rx_buf[0]); end
        total++; if (rx_buf[4] !== 8'h33) begin bad++; $display("FAIL b2b_byte4 got=%h want=33", rx_buf[4]); end
        total++; if (rx_buf[7] !== 8'h33) begin bad++; $display("FAIL b2b_byte7 got=%h want=33", rx_buf[7]); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp [13];
        int at, d0;
        exp = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36, 8'h2E, 8'h37, 8'h38, 8'h0D, 8'h0A};
        hour = 5'd12; min = 6'd34; sec = 6'd56; msec = 7'd78;
        d0 = done_cnt;
        start_frame();
        repeat (445) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (o_tx !== 1'b1) begin bad++; $display("FAIL rstmid_tx got=%b want=1", o_tx); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", o_busy); end
        total++; if (o_done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", o_done); end
        i_send = 1'b1;
        @(negedge clk);
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_wins_busy got=%b want=0", o_busy); end
        i_send = 1'b0; rst = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (done_cnt - d0 !== 0) begin bad++; $display("FAIL rstmid_no_done got=%0d want=0", done_cnt - d0); end
        start_frame();
        rx_line();
        total++; if (!rx_ok) begin bad++; $display("FAIL rstmid_framing got=%b want=1", rx_ok); end
        for (int k = 0; k < 13; k++) begin
            total++;
            if (rx_buf[k] !== exp[k]) begin bad++; $display("FAIL rstmid_byte%0d got=%h want=%h", k, rx_buf[k], exp[k]); end
        end
        wait_done(at);
        total++; if (at !== t0 + 1300) begin bad++; $display("FAIL rstmid_done_time got=%0d want=%0d", at - t0, 1300); end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_snapshot();
        test_busy_ignore();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
